// File: rtl/perf_latency_monitor_pkg.sv
// Shared definitions for the latency monitor: register map,
// control/status bit positions and per-channel statistics bundle.
package perf_latency_monitor_pkg;

  localparam int unsigned ChStride = 32'h20;

  localparam logic [4:0] OffCtrl   = 5'h00;
  localparam logic [4:0] OffStatus = 5'h04;
  localparam logic [4:0] OffCount  = 5'h08;
  localparam logic [4:0] OffSumLo  = 5'h0C;
  localparam logic [4:0] OffSumHi  = 5'h10;
  localparam logic [4:0] OffMin    = 5'h14;
  localparam logic [4:0] OffMax    = 5'h18;
  localparam logic [4:0] OffLast   = 5'h1C;

  localparam int unsigned CtrlEn   = 0;
  localparam int unsigned CtrlClr  = 1;
  localparam int unsigned CtrlMask = 2;

  localparam int unsigned StsOvf   = 0;
  localparam int unsigned StsOrph  = 1;

  typedef struct packed {
    logic [31:0] count;
    logic [63:0] sum;
    logic [31:0] min;
    logic [31:0] max;
    logic [31:0] last;
  } ch_stats_t;

  localparam ch_stats_t StatsReset = '{
    count: '0,
    sum:   '0,
    min:   '1,
    max:   '0,
    last:  '0
  };

  function automatic logic [63:0] sat_add64(
    input logic [63:0] a,
    input logic [31:0] b
  );
    logic [64:0] s;
    s = {1'b0, a} + {33'b0, b};
    return s[64] ? '1 : s[63:0];
  endfunction

endpackage

// File: rtl/perf_latency_channel.sv
// One monitored channel: timestamp FIFO, latency subtract,
// statistics and sticky overflow/orphan flags.
module perf_latency_channel
  import perf_latency_monitor_pkg::*;
#(
  parameter int unsigned CntWidth = 32,
  parameter int unsigned Depth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CntWidth-1:0] i_ts,
  input  logic                i_en,
  input  logic                i_flush,
  input  logic                i_inp_fire,
  input  logic                i_oup_fire,
  input  logic [1:0]          i_sts_w1c,
  output ch_stats_t           o_stats,
  output logic [1:0]          o_status
);

  logic                w_push_req;
  logic                w_pop_req;
  logic                w_fifo_ready;
  logic                w_fifo_valid;
  logic                w_bypass;
  logic                w_upd;
  logic                w_ovf;
  logic                w_orph;
  logic [1:0]          w_set;
  logic [CntWidth-1:0] w_head;
  logic [CntWidth-1:0] w_lat;
  logic [31:0]         w_lat32;
  ch_stats_t           r_stats;
  logic [1:0]          r_status;

  assign w_push_req = i_inp_fire & i_en;
  assign w_pop_req  = i_oup_fire & i_en;

  // Ingress and egress together on an empty FIFO pass
  // straight through with zero latency.
  assign w_bypass = w_push_req & w_pop_req & ~w_fifo_valid;
  assign w_upd    = w_pop_req & (w_fifo_valid | w_push_req);
  assign w_ovf    = w_push_req & ~w_bypass & ~w_fifo_ready;
  assign w_orph   = w_pop_req & ~w_fifo_valid & ~w_push_req;
  assign w_lat    = w_bypass ? '0 : i_ts - w_head;
  assign w_lat32  = 32'(w_lat);

  always_comb begin
    w_set          = '0;
    w_set[StsOvf]  = w_ovf;
    w_set[StsOrph] = w_orph;
  end

  stream_fifo #(
    .Width (CntWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (i_flush),
    .valid_i (w_push_req & ~w_bypass),
    .ready_o (w_fifo_ready),
    .data_i  (i_ts),
    .valid_o (w_fifo_valid),
    .ready_i (w_pop_req),
    .data_o  (w_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stats <= StatsReset;
    end else if (i_flush) begin
      r_stats <= StatsReset;
    end else if (w_upd) begin
      r_stats.last <= w_lat32;
      if (r_stats.count != '1)
        r_stats.count <= r_stats.count + 32'd1;
      r_stats.sum <= sat_add64(r_stats.sum, w_lat32);
      if (w_lat32 < r_stats.min) r_stats.min <= w_lat32;
      if (w_lat32 > r_stats.max) r_stats.max <= w_lat32;
    end
  end

  // New flag events override a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_status <= '0;
    end else if (i_flush) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~i_sts_w1c) | w_set;
    end
  end

  assign o_stats  = r_stats;
  assign o_status = r_status;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// ready_o also rises when full but popping, so push+pop can overlap.
module stream_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] Full = (AW+1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign valid_o = (r_cnt != '0);
  assign ready_o = (r_cnt != Full) | ready_i;
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push)
                     - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/perf_latency_monitor.sv
// Handshake latency monitor: timestamp counter, channel array,
// config decode, registered read mux and interrupt OR.
module perf_latency_monitor
  import perf_latency_monitor_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned CntWidth    = 32,
  parameter int unsigned Depth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] inp_valid_i,
  input  logic [NumChannels-1:0] inp_ready_i,
  input  logic [NumChannels-1:0] oup_valid_i,
  input  logic [NumChannels-1:0] oup_ready_i,
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [8:0]             cfg_addr_i,
  input  logic [31:0]            cfg_wdata_i,
  output logic [31:0]            cfg_rdata_o,
  output logic                   cfg_error_o,
  output logic                   irq_o
);

  logic [CntWidth-1:0]    r_ts;
  logic [NumChannels-1:0] r_en;
  logic [NumChannels-1:0] r_mask;
  logic [NumChannels-1:0] w_ctrl_we;
  logic [NumChannels-1:0] w_sts_we;
  logic [NumChannels-1:0] w_flush;
  logic [1:0]             w_status [NumChannels];
  ch_stats_t              w_stats  [NumChannels];
  logic [3:0]             w_ch;
  logic [4:0]             w_off;
  logic                   w_hit;
  logic [31:0]            w_rval;
  logic                   w_irq;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic                   w_unused;

  assign w_unused = ^cfg_wdata_i[31:3];

  assign w_ch  = cfg_addr_i[8:5];
  assign w_off = {cfg_addr_i[4:2], 2'b00};
  assign w_hit = ({1'b0, cfg_addr_i}
                  < 10'(NumChannels * ChStride))
               & (cfg_addr_i[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + CntWidth'(1);
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    logic w_sel;

    assign w_sel = cfg_req_i & cfg_we_i & w_hit
                 & (w_ch == 4'(g));
    assign w_ctrl_we[g] = w_sel & (w_off == OffCtrl);
    assign w_sts_we[g]  = w_sel & (w_off == OffStatus);

    // Flush on explicit clear or on an enable falling edge.
    assign w_flush[g] = w_ctrl_we[g]
      & (cfg_wdata_i[CtrlClr]
         | (r_en[g] & ~cfg_wdata_i[CtrlEn]));

    perf_latency_channel #(
      .CntWidth (CntWidth),
      .Depth    (Depth)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_ts       (r_ts),
      .i_en       (r_en[g]),
      .i_flush    (w_flush[g]),
      .i_inp_fire (inp_valid_i[g] & inp_ready_i[g]),
      .i_oup_fire (oup_valid_i[g] & oup_ready_i[g]),
      .i_sts_w1c  (w_sts_we[g] ? cfg_wdata_i[1:0]
                               : 2'b00),
      .o_stats    (w_stats[g]),
      .o_status   (w_status[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en   <= '0;
      r_mask <= '0;
    end else begin
      for (int i = 0; i < NumChannels; i++) begin
        if (w_ctrl_we[i]) begin
          r_en[i]   <= cfg_wdata_i[CtrlEn];
          r_mask[i] <= cfg_wdata_i[CtrlMask];
        end
      end
    end
  end

  always_comb begin
    w_rval = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (w_ch == 4'(i)) begin
        unique case (1'b1)
          w_off == OffCtrl:
            w_rval = 32'({r_mask[i], 1'b0, r_en[i]});
          w_off == OffStatus:
            w_rval = 32'(w_status[i]);
          w_off == OffCount:
            w_rval = w_stats[i].count;
          w_off == OffSumLo:
            w_rval = w_stats[i].sum[31:0];
          w_off == OffSumHi:
            w_rval = w_stats[i].sum[63:32];
          w_off == OffMin:
            w_rval = w_stats[i].min;
          w_off == OffMax:
            w_rval = w_stats[i].max;
          w_off == OffLast:
            w_rval = w_stats[i].last;
          default:
            w_rval = '0;
        endcase
      end
    end
  end

  always_comb begin
    w_irq = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      w_irq = w_irq | ((|w_status[i]) & ~r_mask[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= (cfg_req_i & ~cfg_we_i & w_hit)
               ? w_rval : '0;
      r_err   <= cfg_req_i & ~w_hit;
    end
  end

  assign cfg_rdata_o = r_rdata;
  assign cfg_error_o = r_err;
  assign irq_o       = w_irq;

endmodule
